// File: rtl/hack_memory_responder_pkg.sv
// Shared address map, status layout and CPU bus payload for the HACK data-memory responder.
package hack_memory_responder_pkg;

  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned SCR_ADDR_W = 13;

  localparam logic [ADDR_W-1:0] RAM_BASE  = 15'h0000;
  localparam logic [ADDR_W-1:0] SCR_BASE  = 15'h4000;
  localparam logic [ADDR_W-1:0] KBD_ADDR  = 15'h6000;
  localparam logic [ADDR_W-1:0] OUT_ADDR  = 15'h6001;
  localparam logic [ADDR_W-1:0] STAT_ADDR = 15'h6002;
  localparam logic [ADDR_W-1:0] CYC_ADDR  = 15'h6003;

  // Bit positions inside the STATUS word
  localparam int unsigned STAT_KBD_FULL  = 0;
  localparam int unsigned STAT_OUT_VALID = 1;
  localparam int unsigned STAT_OVERFLOW  = 2;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_SCR,
    REG_KBD,
    REG_OUT,
    REG_STAT,
    REG_CYC
  } region_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we;
  } cpu_req_t;

  // Map a CPU address to the target it selects; unimplemented holes map to REG_NONE
  function automatic region_e decode_addr(input logic [ADDR_W-1:0] a,
                                          input int unsigned ram_words,
                                          input int unsigned scr_words);
    region_e r;
    r = REG_NONE;
    if (a[14] == 1'b0) begin
      if (32'(a - RAM_BASE) < ram_words) r = REG_RAM;
    end else if (a[13] == 1'b0) begin
      if (32'(a - SCR_BASE) < scr_words) r = REG_SCR;
    end else begin
      case (a)
        KBD_ADDR:  r = REG_KBD;
        OUT_ADDR:  r = REG_OUT;
        STAT_ADDR: r = REG_STAT;
        CYC_ADDR:  r = REG_CYC;
        default:   r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/hack_screen_ram.sv
// Screen buffer: CPU write + combinational read, scanner port with a registered read.
module hack_screen_ram
  import hack_memory_responder_pkg::*;
#(
  parameter int unsigned SCR_WORDS = 8192
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_we_i,
  input  logic [SCR_ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0]     cpu_wdata_i,
  output logic [DATA_W-1:0]     cpu_rdata_o,
  input  logic [SCR_ADDR_W-1:0] scan_addr_i,
  output logic [DATA_W-1:0]     scan_data_o
);

  localparam int unsigned SCR_AW = $clog2(SCR_WORDS);

  logic [DATA_W-1:0] mem [SCR_WORDS];
  logic [DATA_W-1:0] scan_data_q, scan_data_d;
  logic              scan_hit;

  assign scan_hit    = 32'(scan_addr_i) < SCR_WORDS;
  assign cpu_rdata_o = mem[cpu_addr_i[SCR_AW-1:0]];
  assign scan_data_o = scan_data_q;

  // CPU write port; contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    if (cpu_we_i) mem[cpu_addr_i[SCR_AW-1:0]] <= cpu_wdata_i;
  end

  // Scanner lookup; a same-edge CPU write is not visible until the next read
  always_comb begin
    scan_data_d = '0;
    if (scan_hit) scan_data_d = mem[scan_addr_i[SCR_AW-1:0]];
  end

  // Registered scanner output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) scan_data_q <= '0;
    else       scan_data_q <= scan_data_d;
  end

endmodule

// File: rtl/hack_memory_responder.sv
// HACK data-memory side: RAM, screen buffer and memory-mapped keyboard/output/status/cycle I/O.
module hack_memory_responder
  import hack_memory_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 16384,
  parameter int unsigned SCR_WORDS = 8192
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addresM,
  input  logic [DATA_W-1:0]     outM,
  input  logic                  writeM,
  output logic [DATA_W-1:0]     inM,
  input  logic [SCR_ADDR_W-1:0] scr_addr,
  output logic [DATA_W-1:0]     scr_data,
  input  logic                  kbd_valid,
  input  logic [DATA_W-1:0]     kbd_code,
  output logic                  kbd_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

  cpu_req_t          req;
  region_e           region;
  logic [RAM_AW-1:0] ram_idx;
  logic [DATA_W-1:0] ram_mem [RAM_WORDS];
  logic [DATA_W-1:0] scr_cpu_rdata;
  logic [DATA_W-1:0] status_w;

  logic [DATA_W-1:0] kbd_q, kbd_d;
  logic              kbd_full_q, kbd_full_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] cyc_q, cyc_d;

  logic kbd_accept, out_pop, wr_ram, wr_scr, wr_kbd, wr_out, wr_stat;

  assign req     = '{addr: addresM, data: outM, we: writeM};
  assign region  = decode_addr(req.addr, RAM_WORDS, SCR_WORDS);
  assign ram_idx = req.addr[RAM_AW-1:0];

  assign wr_ram  = req.we && (region == REG_RAM);
  assign wr_scr  = req.we && (region == REG_SCR);
  assign wr_kbd  = req.we && (region == REG_KBD);
  assign wr_out  = req.we && (region == REG_OUT);
  assign wr_stat = req.we && (region == REG_STAT);

  assign kbd_accept = kbd_valid && !kbd_full_q;
  assign out_pop    = out_valid_q && out_ready;

  assign kbd_ready = ~kbd_full_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  hack_screen_ram #(.SCR_WORDS(SCR_WORDS)) u_screen (
    .clk_i       (clk),
    .rst_i       (reset),
    .cpu_we_i    (wr_scr),
    .cpu_addr_i  (req.addr[SCR_ADDR_W-1:0]),
    .cpu_wdata_i (req.data),
    .cpu_rdata_o (scr_cpu_rdata),
    .scan_addr_i (scr_addr),
    .scan_data_o (scr_data)
  );

  // Main data RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ram) ram_mem[ram_idx] <= req.data;
  end

  // Status word assembled from live flags
  always_comb begin
    status_w                 = '0;
    status_w[STAT_KBD_FULL]  = kbd_full_q;
    status_w[STAT_OUT_VALID] = out_valid_q;
    status_w[STAT_OVERFLOW]  = ovf_q;
  end

  // Zero-latency read mux back to the CPU
  always_comb begin
    inM = '0;
    case (region)
      REG_RAM:  inM = ram_mem[ram_idx];
      REG_SCR:  inM = scr_cpu_rdata;
      REG_KBD:  inM = kbd_q;
      REG_OUT:  inM = out_data_q;
      REG_STAT: inM = status_w;
      REG_CYC:  inM = cyc_q;
      default:  inM = '0;
    endcase
  end

  // Next state for I/O registers; fullness is always judged on start-of-cycle state
  always_comb begin
    kbd_d       = kbd_q;
    kbd_full_d  = kbd_full_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;
    cyc_d       = cyc_q + 16'd1;

    if (wr_kbd) begin
      kbd_d      = '0;
      kbd_full_d = 1'b0;
    end
    // Accept only happens on an empty register, so it overrides a same-cycle clear
    if (kbd_accept) begin
      kbd_d      = kbd_code;
      kbd_full_d = 1'b1;
    end

    if (out_pop) out_valid_d = 1'b0;
    if (wr_out) begin
      if (out_valid_q) begin
        ovf_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = req.data;
      end
    end
    if (wr_stat) ovf_d = 1'b0;
  end

  // I/O state registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_q       <= '0;
      kbd_full_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
      cyc_q       <= '0;
    end else begin
      kbd_q       <= kbd_d;
      kbd_full_q  <= kbd_full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
      cyc_q       <= cyc_d;
    end
  end

endmodule

// File: doc/hack_memory_responder.md
Name: hack_memory_responder

Overview:
- Data-memory side of the HACK CPU bus: decodes the CPU's addresM, writeM and outM, and returns inM.
- Contains three things:
  - the main data RAM;
  - a screen buffer with a second registered read port for the display scanner;
  - memory-mapped I/O: a keyboard holding register, a one-entry output-port buffer, a status word and a free-running cycle counter.
- Sits beside the CPU in the top level, with inM fed straight back to the CPU.

Parameters:
- RAM_WORDS, 16384, number of implemented data-RAM words at 0x0000 up to 0x3FFF.
- SCR_WORDS, 8192, number of screen-buffer words at 0x4000 up to 0x5FFF.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- addresM  in  15  CPU data address.
- outM  in  16  CPU write data.
- writeM  in  1  CPU write strobe, sampled at the rising edge of clk.
- inM  out  16  read data to the CPU; combinational from addresM.
- scr_addr  in  13  display-scanner read address.
- scr_data  out  16  screen word at scr_addr, registered (1-cycle latency).
- kbd_valid  in  1  keyboard source offers a code.
- kbd_code  in  16  key code; must be nonzero while kbd_valid is high.
- kbd_ready  out  1  holding register empty; a code is accepted when kbd_valid and kbd_ready are both high.
- out_valid  out  1  output buffer holds a word.
- out_data  out  16  buffered output word.
- out_ready  in  1  sink accepts the word; a pop occurs when out_valid and out_ready are both high.

Behaviour:
- Reset, asynchronous and immediate:
  - kbd register = 0, kbd_full = 0, kbd_ready = 1;
  - out_valid = 0, out_data = 0, overflow = 0;
  - cycle counter = 0, scr_data = 0.
  - RAM and screen contents are not reset.
- Read path:
  - inM is purely combinational from addresM and the current state, with zero latency.
  - The single-cycle CPU relies on this combinational path.
- Write path: when writeM = 1 at a clock edge, the decoded target updates at that edge. Reads have no side effects.
- Address map:
  - 0x0000 up to RAM_WORDS-1: RAM read/write. Addresses from RAM_WORDS up to 0x3FFF read 0 and ignore writes.
  - 0x4000 up to 0x4000+SCR_WORDS-1: screen buffer read/write. The CPU port is combinational read; the scanner port is a registered read. A same-cycle CPU write and scanner read of the same word returns the old data.
  - 0x6000 KBD:
    - Read returns the kbd register (0 when empty).
    - A write of any value clears the register to 0 and kbd_full to 0.
  - 0x6001 OUT:
    - Write pushes outM into the buffer only if out_valid = 0 at the start of the cycle.
    - If out_valid = 1 at the start of the cycle, the push is dropped and overflow is set.
    - Read returns out_data.
  - 0x6002 STATUS:
    - Read returns {13'b0, overflow, out_valid, kbd_full}.
    - Any write clears overflow.
  - 0x6003 CYCLES: read-only. Low 16 bits of a free-running counter that increments every cycle and wraps from 0xFFFF to 0. Writes are ignored.
  - Every other address reads 0 and ignores writes.
- Keyboard handshake:
  - kbd_ready = ~kbd_full.
  - On accept, the register loads kbd_code and kbd_full becomes 1 at that edge.
  - A CPU clear and a new accept cannot collide: accept requires empty and clear requires nothing. If both occur in the same cycle on an empty register, the accept wins.
- Output handshake:
  - A pop clears out_valid at the edge.
  - A pop and a push in the same cycle while full: the push is dropped and overflow is set, because fullness is judged at the start of the cycle. The buffer is empty afterwards.
  - A push while empty sets out_valid on the next cycle. out_data holds stable while out_valid = 1.
- Reset mid-operation: a pending keyboard code or output word is discarded; the external side observes kbd_ready = 1 and out_valid = 0 immediately.

Decomposition:
- Shared package holds:
  - address constants: RAM_BASE, SCR_BASE = 0x4000, KBD_ADDR = 0x6000, OUT_ADDR = 0x6001, STAT_ADDR = 0x6002, CYC_ADDR = 0x6003;
  - status bit positions.
- One natural sub-module, hack_screen_ram: dual-port memory with CPU write plus combinational read, and a registered scanner read.
- RAM, keyboard, output and counter logic stay in the top.

Test Plan:
- RAM: write 0x1234 to 0x0005, then read 0x0005 → inM = 0x1234 in the same cycle. Write to 0x3FFF with RAM_WORDS = 1024 → readback is 0.
- Screen: CPU writes 0xBEEF to 0x4010; scanner sets scr_addr = 0x0010 → scr_data = 0xBEEF one cycle later. Same-cycle write and scan of that word → old value.
- Keyboard: kbd_valid = 1, kbd_code = 0x0041 → accepted and kbd_ready drops. A second code 0x0042 is held off. Read 0x6000 → 0x0041. CPU writes 0x6000 → read gives 0, kbd_ready = 1, and 0x0042 is then accepted.
- Output: push 0x00AA with out_ready = 0 → out_valid = 1. Push 0x00BB → dropped, STATUS = 0x0006. Raise out_ready → one pop of 0x00AA. Write STATUS → overflow is cleared.
- Counter: after reset, read 0x6003 at cycle N → value N. After 65536 cycles it wraps to the same value.
- Async reset asserted mid-transfer with out_valid = 1 and kbd_full = 1 → both clear immediately without waiting for a clock edge. RAM data written before the reset reads back unchanged.
